// File: rtl/stream_rr_arbiter_pkg.sv
// stream_rr_arbiter_pkg: definitions shared by stream_rr_arbiter and rr_pick.
// Holds the requester ceiling, the source-tag width helper and the default
// data width. These are the contents otherwise kept in stream_arb_defs.vh.
// They live here so that every consumer gets them through a package import.
// The optional burst lock is selected with STREAM_RR_ARBITER_LOCK_EN and is
// handled in stream_rr_arbiter.sv.

`ifndef intN
`define intN 32
`endif

package stream_rr_arbiter_pkg;

  // Largest requester count any arbiter built on rr_pick supports.
  localparam int STREAM_ARB_MAX_REQ = 8;

  // Tag width needed to encode n requesters. Never returns less than 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker. Given a request vector and a
// starting priority index, it returns the first requester found when scanning
// prio, prio+1, ... (mod NUM_REQ). The result is a one-hot grant, its index
// and an "any" flag. It is shared with other resource schedulers.

module rr_pick
  import stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_prio,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SRC_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan from the farthest offset down to prio so the nearest request wins.
  always_comb begin
    int                 w_pos;
    logic [SRC_W-1:0]   w_sel;
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    w_sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = (int'(i_prio) + k) % NUM_REQ;
      w_sel = SRC_W'(w_pos);
      if (i_req[w_sel]) begin
        o_grant        = '0;
        o_grant[w_sel] = 1'b1;
        o_idx          = w_sel;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: shares one registered output slot between NUM_REQ
// valid/ready producers, using round-robin arbitration. Each word is tagged
// with the index of its source.
// Optional feature: define STREAM_RR_ARBITER_LOCK_EN to hold the grant on one
// producer until it presents sIn_last. Without it, arbitration is per word and
// sIn_last is ignored.

module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = `intN,
  parameter int SRC_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*W-1:0] sIn,
  input  logic [NUM_REQ-1:0]   sIn_valid,
  output logic [NUM_REQ-1:0]   sIn_ready,
  input  logic [NUM_REQ-1:0]   sIn_last,
  output logic [W-1:0]         sOut,
  output logic                 sOut_valid,
  input  logic                 sOut_ready,
  output logic [SRC_W-1:0]     sOut_src
);

  // Reject impossible configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > STREAM_ARB_MAX_REQ) begin : g_bad_num_req
    $error("stream_rr_arbiter: NUM_REQ must be in 2..%0d", STREAM_ARB_MAX_REQ);
  end
  if (SRC_W != clog2_min1(NUM_REQ)) begin : g_bad_src_w
    $error("stream_rr_arbiter: SRC_W must equal clog2(NUM_REQ), minimum 1");
  end

  logic [SRC_W-1:0]   r_prio;
  logic               r_out_valid;
  logic [W-1:0]       r_out_data;
  logic [SRC_W-1:0]   r_out_src;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]   w_idx;
  logic               w_any;
  logic               w_slot_free;
  logic               w_xfer;
  logic               w_prio_upd;
  logic [SRC_W-1:0]   w_next_prio;
  logic [W-1:0]       w_sel_data;

  // The slot can take a word when it is empty or is being drained this cycle.
  assign w_slot_free = !r_out_valid || sOut_ready;

`ifdef STREAM_RR_ARBITER_LOCK_EN
  logic               r_lock;
  logic [SRC_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] w_owner_mask;
  logic               w_last;

  // One-hot mask of the current burst owner.
  always_comb begin
    w_owner_mask          = '0;
    w_owner_mask[r_owner] = 1'b1;
  end

  // While locked, only the owner may compete. An idle owner therefore stalls
  // everyone else.
  assign w_req  = r_lock ? (sIn_valid & w_owner_mask) : sIn_valid;
  assign w_last = sIn_last[w_idx];

  // Priority moves on only when a burst ends (or for a single-word burst).
  // On release this yields owner+1.
  assign w_prio_upd = w_xfer && w_last;

  // Lock on a non-final word and release on the owner's final word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else if (w_xfer) begin
      if (!w_last) begin
        r_lock  <= 1'b1;
        r_owner <= w_idx;
      end else begin
        r_lock  <= 1'b0;
      end
    end
  end
`else
  logic w_unused_last;

  assign w_req         = sIn_valid;
  assign w_prio_upd    = w_xfer;
  assign w_unused_last = ^sIn_last;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_pick (
    .i_req   (w_req),
    .i_prio  (r_prio),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Ready is the grant qualified by slot space. It is forced low during reset.
  assign sIn_ready  = rst ? '0 : (w_grant & {NUM_REQ{w_slot_free}});
  assign w_xfer     = !rst && w_any && w_slot_free;
  assign w_sel_data = sIn[int'(w_idx)*W +: W];
  assign w_next_prio = (w_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  // Round-robin pointer: starts the next scan just past the last winner.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, whatever order the blocks run in.
    if (rst) begin
      r_prio <= '0;
    end else if (w_prio_upd) begin
      r_prio <= w_next_prio;
    end
  end

  // Output slot: load on transfer, empty on consume without refill.
  always_ff @(posedge clk) begin
    // NOTE: the data and tag registers are reset along with valid. This keeps
    // the post-reset output deterministic instead of leaking a dropped word.
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_src   <= w_idx;
    end else if (sOut_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign sOut       = r_out_data;
  assign sOut_valid = r_out_valid;
  assign sOut_src   = r_out_src;

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares one downstream stream consumer, such as a `__primitive_pushr1_lli` instance, between up to NUM_REQ upstream stream producers. Each producer offers `intN`-wide data with valid/ready handshaking. The arbiter grants one producer per cycle and registers the winning word into a single output slot, tagging it with the source index. Optional burst locking keeps the grant on one producer until it marks the end of its burst.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `W`, default `` `intN ``: data width.
- `SRC_W`, default 2: source-tag width; must equal clog2(NUM_REQ), minimum 1.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `sIn`, in, NUM_REQ*W: requester data, flattened; requester i occupies bits [i*W +: W].
- `sIn_valid`, in, NUM_REQ: per-requester valid.
- `sIn_ready`, out, NUM_REQ: per-requester ready; at most one bit high per cycle.
- `sIn_last`, in, NUM_REQ: per-requester end-of-burst flag; used only when locking is compiled in.
- `sOut`, out, W: registered output data.
- `sOut_valid`, out, 1: output slot full.
- `sOut_ready`, in, 1: downstream accepts.
- `sOut_src`, out, SRC_W: index of the requester that produced `sOut`.

## Operation
- A transfer on requester i happens when `sIn_valid[i] && sIn_ready[i]`. A transfer on the output happens when `sOut_valid && sOut_ready`.
- `slot_free = !sOut_valid || sOut_ready`.
- Grant selection is combinational:
  - Unlocked: the first i with `sIn_valid[i]` set, scanning `prio, prio+1, … prio+NUM_REQ-1`, indices taken mod NUM_REQ.
  - Locked: only `owner` can be granted.
- `sIn_ready[i] = grant[i] && slot_free`. Ready depends on valid; this combinational path is permitted.
- On a transfer from requester i:
  - `sOut <= sIn[i]`, `sOut_src <= i`, `sOut_valid <= 1`.
  - `prio <= (i+1) mod NUM_REQ`. Wrap from NUM_REQ-1 goes to 0.
- Output consumed with no new input transfer: `sOut_valid <= 0`. `sOut` and `sOut_src` hold their values.
- Simultaneous consume and refill in the same cycle: the slot reloads and `sOut_valid` stays 1, giving full throughput.
- Output stalled (`sOut_valid && !sOut_ready`): all `sIn_ready` are 0; `prio` and the lock state hold.
- No requester valid: no grant; `prio` holds.
- State: `prio` (SRC_W bits), `lock` (1 bit), `owner` (SRC_W bits), output register.

## Timing
- Reset values: `sOut_valid`=0, `sOut`=0, `sOut_src`=0, `prio`=0, `lock`=0, `owner`=0.
- While `rst` is high, `sIn_ready` is forced to 0.
- A reset mid-burst or with the output slot full drops the held word and releases any lock.
- Latency: an input transfer in cycle n makes `sOut_valid` high in cycle n+1.
- Throughput: one word per cycle while `sOut_ready` stays high.
- Fairness: with all requesters continuously valid and locking disabled, grants follow 0,1,…,NUM_REQ-1,0,…
- Starvation bound: NUM_REQ-1 foreign grants when unlocked.

## Configuration
- Macro: `STREAM_RR_ARBITER_LOCK_EN`.
- Defined:
  - A transfer from i with `sIn_last[i]`=0 sets `lock`=1 and `owner`=i.
  - A transfer from the owner with `sIn_last`=1 clears `lock`.
  - While locked, `prio` is not updated until release; on release, `prio <= owner+1`.
  - An idle owner (valid=0) blocks all other requesters.
- Undefined:
  - `sIn_last` is ignored, `lock` is tied to 0, and no `owner` register is generated.
  - Arbitration is per word.

## Structure
- Shared include `stream_arb_defs.vh`, holding:
  - `` `STREAM_ARB_MAX_REQ `` (8).
  - The clog2 macro used to check SRC_W.
  - Slice macros for the flattened `sIn` bus.
- One sub-module, `rr_pick`: purely combinational. Takes a `NUM_REQ`-bit request vector and `prio`, and returns a one-hot `grant` plus its encoded index. Both `stream_rr_arbiter` and future shared-resource schedulers reuse it.

## Test plan
- Reset release, all valid, `sOut_ready`=1, NUM_REQ=4, data 10/20/30/40 -> `sOut_src` sequence 0,1,2,3,0; `sOut` 10,20,30,40,10; `sOut_valid` first high one cycle after the first transfer.
- Only requester 2 valid, data incrementing from 1 -> one word per cycle; `sOut` = 1,2,3…, `sOut_src`=2, `prio`=3 after each transfer.
- `sOut_ready`=0 for 3 cycles with the slot full (`sOut`=42) -> `sOut` holds 42, all `sIn_ready`=0; on ready=1, one consume-and-refill cycle with `sOut_valid` staying 1.
- Lock enabled: requester 1 sends 3 words with last=0,0,1 while requester 0 is valid -> `sOut_src` sequence 1,1,1,0; requester 0 is not granted before 1's last word.
- Lock enabled: `rst` pulsed mid-burst of requester 3 -> `sOut_valid`=0 next cycle, `lock`=0; with all valid after release, requester 0 is granted first.
- Requester 3 wins, then all valid -> next grant is 0 (wrap-around of `prio`).
